two_com_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer that shares a single `two_com_gate` (4-bit two's-complement negator) between two clients. It registers the winner's operand, runs it through the shared gate, and holds the tagged result with a valid/ack handshake until the consumer takes it. It sits between two operand producers and one result consumer in the Ch07 arithmetic datapath.

---
 rtl/two_com_pkg.sv | 16 +
 rtl/two_com_gate.sv | 12 +
 rtl/two_com_arb.sv | 91 +++++++++
 tb/tb_two_com_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_com_pkg.sv
// Shared definitions for the two-client negator arbiter: FSM state codes,
// datapath width and the one operand whose negation overflows.
package two_com_pkg;

    localparam int WIDTH = 4;

    // The most negative 4-bit value negates to itself, so it flags overflow
    localparam logic [WIDTH-1:0] OVF_PATTERN = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/two_com_gate.sv
// Purely combinational two's-complement negator: O = (-I) mod 16.
module two_com_gate
    import two_com_pkg::*;
(
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O
);

    // Invert and add one; wraps naturally modulo 2^WIDTH
    assign O = ~I + WIDTH'(1);

endmodule

// File: rtl/two_com_arb.sv
// Round-robin arbiter and sequencer sharing one two_com_gate between two
// operand producers. The winner's operand is latched, negated on the next
// cycle and the tagged result is held until the consumer acknowledges it.
module two_com_arb
    import two_com_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] I0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] I1,
    input  logic             ACK,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] O,
    output logic             OVF,
    output logic             ID,
    output logic             VALID,
    output logic             BUSY
);

    state_t           state;
    logic             ptr;
    logic             win;
    logic             pick;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] neg_a;

    two_com_gate u_gate (
        .I (a),
        .O (neg_a)
    );

    // A lone requester always wins; on a tie the priority pointer decides
    assign pick = (REQ0 && REQ1) ? ptr : REQ1;

    // Busy whenever a transaction is in flight
    assign BUSY = (state != IDLE);

    // Arbitration, sequencing and all registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= 1'b0;
            win   <= 1'b0;
            a     <= '0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            O     <= '0;
            OVF   <= 1'b0;
            ID    <= 1'b0;
            VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        win   <= pick;
                        a     <= pick ? I1 : I0;
                        GNT0  <= ~pick;
                        GNT1  <= pick;
                        state <= CALC;
                    end
                end
                CALC: begin
                    GNT0  <= 1'b0;
                    GNT1  <= 1'b0;
                    O     <= neg_a;
                    OVF   <= (a == OVF_PATTERN);
                    ID    <= win;
                    VALID <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (ACK) begin
                        VALID <= 1'b0;
                        ptr   <= ~win;
                        state <= IDLE;
                    end
                end
                default: begin
                    GNT0  <= 1'b0;
                    GNT1  <= 1'b0;
                    VALID <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_two_com_arb.sv
// Self-checking bench for two_com_arb: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbiter.
module tb_two_com_arb;

    logic       CLK;
    logic       RST_N;
    logic       REQ0;
    logic [3:0] I0;
    logic       REQ1;
    logic [3:0] I1;
    logic       ACK;
    logic       GNT0;
    logic       GNT1;
    logic [3:0] O;
    logic       OVF;
    logic       ID;
    logic       VALID;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    two_com_arb dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ0  (REQ0),
        .I0    (I0),
        .REQ1  (REQ1),
        .I1    (I1),
        .ACK   (ACK),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .O     (O),
        .OVF   (OVF),
        .ID    (ID),
        .VALID (VALID),
        .BUSY  (BUSY)
    );

    // Free-running 10-time-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case anything stalls the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge, then settle so outputs are sampled off-edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference negation straight from the arithmetic definition
    function automatic logic [3:0] neg4(input int v);
        return 4'((16 - v) % 16);
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        mptr  = 0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; ACK = 1'b0; I0 = '0; I1 = '0;
        tick();
        tick();
        total++;
        if ({GNT0, GNT1, VALID, OVF, ID, BUSY} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b required 000000", {GNT0, GNT1, VALID, OVF, ID, BUSY});
        end
        total++;
        if (O !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_o: got %b required 0000", O);
        end
        RST_N = 1'b1;
        mptr  = 0;
    endtask

    task automatic test_single();
        REQ0 = 1'b1; I0 = 4'b0011; ACK = 1'b1;
        tick();
        total++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0 || BUSY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_gnt: got gnt0=%b gnt1=%b busy=%b required 1 0 1", GNT0, GNT1, BUSY);
        end
        // Operand changes right after the grant; the latched value must win
        REQ0 = 1'b0; I0 = 4'($urandom_range(0, 15));
        tick();
        total++;
        if (VALID !== 1'b1 || O !== 4'b1101 || ID !== 1'b0 || GNT0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_result: got v=%b o=%b id=%b gnt0=%b required 1 1101 0 0", VALID, O, ID, GNT0);
        end
        tick();
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_width: got v=%b busy=%b required 0 0", VALID, BUSY);
        end
        mptr = 1;
    endtask

    task automatic test_both_alternate();
        int w;
        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; I0 = 4'b0001; I1 = 4'b0111; ACK = 1'b1;
        for (int t = 0; t < 4; t++) begin
            w = mptr;
            tick();
            total++;
            if ({GNT1, GNT0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("[TB] FAIL alt_gnt[%0d]: got gnt1gnt0=%b required winner %0d", t, {GNT1, GNT0}, w);
            end
            tick();
            total++;
            if (VALID !== 1'b1 || ID !== 1'(w) || O !== neg4((w == 1) ? 7 : 1)) begin
                bad++;
                $display("[TB] FAIL alt_result[%0d]: got v=%b id=%b o=%b required 1 %0d %b", t, VALID, ID, O, w, neg4((w == 1) ? 7 : 1));
            end
            tick();
            mptr = 1 - w;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
    endtask

    task automatic test_ovf_zero();
        logic [3:0] ops [2];
        ops[0] = 4'b1000;
        ops[1] = 4'b0000;
        ACK = 1'b1;
        for (int k = 0; k < 2; k++) begin
            REQ1 = 1'b1; I1 = ops[k];
            tick();
            total++;
            if (GNT1 !== 1'b1 || GNT0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ovf_gnt[%0d]: got gnt1=%b gnt0=%b required 1 0", k, GNT1, GNT0);
            end
            REQ1 = 1'b0;
            tick();
            total++;
            if (VALID !== 1'b1 || O !== ops[k] || OVF !== (ops[k] == 4'b1000) || ID !== 1'b1) begin
                bad++;
                $display("[TB] FAIL ovf_result[%0d]: got o=%b ovf=%b id=%b required %b %b 1", k, O, OVF, ID, ops[k], (ops[k] == 4'b1000));
            end
            tick();
            mptr = 0;
        end
    endtask

    task automatic test_ack_stall();
        REQ0 = 1'b1; I0 = 4'b0110; ACK = 1'b0;
        tick();
        total++;
        if (GNT0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_gnt0: got %b required 1", GNT0);
        end
        REQ0 = 1'b0;
        tick();
        REQ1 = 1'b1; I1 = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (VALID !== 1'b1 || O !== 4'b1010 || ID !== 1'b0 || GNT1 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b o=%b id=%b gnt1=%b required 1 1010 0 0", c, VALID, O, ID, GNT1);
            end
        end
        ACK = 1'b1;
        tick();
        total++;
        if (VALID !== 1'b0 || GNT1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_release: got v=%b gnt1=%b required 0 0", VALID, GNT1);
        end
        tick();
        total++;
        if (GNT1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_gnt1: got %b required 1", GNT1);
        end
        REQ1 = 1'b0;
        tick();
        total++;
        if (VALID !== 1'b1 || O !== 4'b1011 || ID !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_result1: got v=%b o=%b id=%b required 1 1011 1", VALID, O, ID);
        end
        tick();
        mptr = 0;
    endtask

    task automatic test_sweep();
        ACK = 1'b1;
        for (int i = 0; i < 16; i++) begin
            REQ0 = 1'b1; I0 = 4'(i);
            tick();
            REQ0 = 1'b0;
            tick();
            total++;
            if (VALID !== 1'b1 || O !== neg4(i) || OVF !== (i == 8) || ID !== 1'b0) begin
                bad++;
                $display("[TB] FAIL sweep[%0d]: got o=%b ovf=%b v=%b required %b %b 1", i, O, OVF, VALID, neg4(i), (i == 8));
            end
            tick();
        end
        mptr = 1;
    endtask

    task automatic test_reset_mid_hold();
        // Serve client 0 first so the pointer favours client 1 before reset
        ACK = 1'b1; REQ0 = 1'b1; I0 = 4'b0010;
        tick();
        REQ0 = 1'b0;
        tick();
        tick();
        REQ1 = 1'b1; I1 = 4'b0101; ACK = 1'b0;
        tick();
        REQ1 = 1'b0;
        tick();
        total++;
        if (VALID !== 1'b1 || O !== 4'b1011) begin
            bad++;
            $display("[TB] FAIL midhold_setup: got v=%b o=%b required 1 1011", VALID, O);
        end
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        mptr  = 0;
        total++;
        if ({GNT0, GNT1, VALID, OVF, ID, BUSY} !== 6'b0 || O !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL midhold_reset: got flags=%b o=%b required 000000 0000", {GNT0, GNT1, VALID, OVF, ID, BUSY}, O);
        end
        REQ0 = 1'b1; REQ1 = 1'b1; I0 = 4'b1001; I1 = 4'b0100; ACK = 1'b1;
        tick();
        total++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midhold_ptr: got gnt0=%b gnt1=%b required 1 0", GNT0, GNT1);
        end
        REQ0 = 1'b0;
        tick();
        total++;
        if (O !== 4'b0111 || ID !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midhold_result: got o=%b id=%b required 0111 0", O, ID);
        end
        tick();
        tick();
        total++;
        if (GNT1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midhold_next: got gnt1=%b required 1", GNT1);
        end
        REQ1 = 1'b0;
        tick();
        tick();
        mptr = 0;
    endtask

    task automatic test_random();
        logic [1:0] rq;
        logic [3:0] rop [2];
        logic [1:0] exp_gnt;
        logic [3:0] mop;
        logic [3:0] exp_o;
        logic       exp_valid;
        logic       exp_ovf;
        logic       exp_id;
        int         stage;
        int         mwin;
        do_reset();
        rq = 2'b00; rop[0] = '0; rop[1] = '0; mop = '0; exp_o = '0;
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_id = 1'b0; stage = 0; mwin = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!rq[c] && $urandom_range(0, 2) == 0) begin
                    rq[c]  = 1'b1;
                    rop[c] = 4'($urandom_range(0, 15));
                end
            end
            REQ0 = rq[0]; I0 = rop[0]; REQ1 = rq[1]; I1 = rop[1];
            ACK  = 1'($urandom_range(0, 1));
            // Model: arbitrate when free, deliver one cycle later, release on ACK
            exp_gnt = 2'b00;
            if (stage == 0) begin
                if (rq != 2'b00) begin
                    mwin = (rq == 2'b11) ? mptr : (rq[1] ? 1 : 0);
                    exp_gnt[mwin] = 1'b1;
                    mop   = rop[mwin];
                    stage = 1;
                end
            end else if (stage == 1) begin
                exp_valid = 1'b1;
                exp_o     = neg4(int'(mop));
                exp_ovf   = (mop == 4'd8);
                exp_id    = (mwin == 1);
                stage     = 2;
            end else if (ACK) begin
                exp_valid = 1'b0;
                mptr      = 1 - mwin;
                stage     = 0;
            end
            tick();
            total++;
            if ({GNT1, GNT0} !== exp_gnt || VALID !== exp_valid || BUSY !== (stage != 0)) begin
                bad++;
                $display("[TB] FAIL rand_ctrl[%0d]: got gnt=%b v=%b busy=%b required %b %b %b", cyc, {GNT1, GNT0}, VALID, BUSY, exp_gnt, exp_valid, (stage != 0));
            end
            if (exp_valid) begin
                total++;
                if (O !== exp_o || OVF !== exp_ovf || ID !== exp_id) begin
                    bad++;
                    $display("[TB] FAIL rand_data[%0d]: got o=%b ovf=%b id=%b required %b %b %b", cyc, O, OVF, ID, exp_o, exp_ovf, exp_id);
                end
            end
            if (GNT0 === 1'b1) rq[0] = 1'b0;
            if (GNT1 === 1'b1) rq[1] = 1'b0;
        end
        REQ0 = 1'b0; REQ1 = 1'b0; ACK = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        test_reset();
        test_single();
        test_both_alternate();
        test_ovf_zero();
        test_ack_stall();
        test_sweep();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
